// File: rtl/hub_pkg.sv
// Shared definitions for the parent link: ID field layout, broadcast ID,
// link word shape and the downstream router FSM states.
package hub_pkg;

    localparam int         ID_W         = 4;
    localparam logic [3:0] ID_BROADCAST = 4'hF;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [59:0]     payload;
    } link_word_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } hub_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index; the search starts at the
// pointer, which moves past the granted requester only when advance is high.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            for (int k = 0; k < N; k++) begin
                if (!found && req[k] && (k == pos)) begin
                    found     = 1'b1;
                    grant[k]  = 1'b1;
                    grant_idx = IDX_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/parent_link_hub.sv
// Root-side parent link endpoint: routes downstream words to per-child slots
// (unicast/broadcast/drop) and merges child upstream words with ID stamping.
module parent_link_hub
    import hub_pkg::*;
#(
    parameter int NUM_CHILDREN = 4,
    parameter int ID_MSB       = 63
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [63:0]                ctrl_in_data,
    input  logic                       ctrl_in_valid,
    output logic                       ctrl_in_ready,
    output logic [63:0]                ctrl_out_data,
    output logic                       ctrl_out_valid,
    input  logic                       ctrl_out_ready,
    output logic [64*NUM_CHILDREN-1:0] child_tx_data,
    output logic [NUM_CHILDREN-1:0]    child_tx_valid,
    input  logic [NUM_CHILDREN-1:0]    child_tx_ready,
    input  logic [64*NUM_CHILDREN-1:0] child_rx_data,
    input  logic [NUM_CHILDREN-1:0]    child_rx_valid,
    output logic [NUM_CHILDREN-1:0]    child_rx_ready,
    output logic [15:0]                drop_count,
    output logic                       hub_busy,
    output hub_state_t                 fsm_state
);

    localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

    // Every channel: a word moves on a cycle where valid && ready; a raised
    // valid keeps its data stable until that cycle.
    hub_state_t              state, state_next;
    logic [NUM_CHILDREN-1:0] slot_valid, slot_free, done_mask, done_next;
    logic [NUM_CHILDREN-1:0] uni_mask, load_mask;
    logic [63:0]             slot_data [NUM_CHILDREN];
    logic [63:0]             bcast_data;
    logic [ID_W-1:0]         dest;
    logic                    is_uni, accept, load_bcast, bcast_accept, drop_inc;

    assign dest      = ctrl_in_data[ID_MSB -: ID_W];
    assign is_uni    = (dest != '0) && (int'(dest) <= NUM_CHILDREN);
    assign slot_free = ~slot_valid | child_tx_ready;
    assign fsm_state = state;

    always_comb begin
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            uni_mask[k] = is_uni && (int'(dest) == k + 1);
        end
    end

    always_comb begin
        state_next    = state;
        done_next     = done_mask;
        load_mask     = '0;
        load_bcast    = 1'b0;
        bcast_accept  = 1'b0;
        drop_inc      = 1'b0;
        ctrl_in_ready = 1'b0;
        if (state == ST_IDLE) begin
            ctrl_in_ready = is_uni ? |(uni_mask & slot_free) : 1'b1;
        end
        if (!reset) ctrl_in_ready = 1'b0;
        accept = ctrl_in_valid && ctrl_in_ready;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_uni) begin
                        load_mask = uni_mask;
                    end else if (dest == ID_BROADCAST) begin
                        bcast_accept = 1'b1;
                        done_next    = '0;
                        state_next   = ST_BCAST;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            ST_BCAST: begin
                load_mask  = slot_free & ~done_mask;
                load_bcast = 1'b1;
                done_next  = done_mask | load_mask;
                if (&done_next) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            done_mask  <= '0;
            bcast_data <= '0;
            drop_count <= '0;
            slot_valid <= '0;
            for (int k = 0; k < NUM_CHILDREN; k++) slot_data[k] <= '0;
        end else begin
            state     <= state_next;
            done_mask <= done_next;
            if (bcast_accept) bcast_data <= ctrl_in_data;
            if (drop_inc && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            for (int k = 0; k < NUM_CHILDREN; k++) begin
                if (load_mask[k]) begin
                    slot_valid[k] <= 1'b1;
                    slot_data[k]  <= load_bcast ? bcast_data : ctrl_in_data;
                end else if (child_tx_ready[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            child_tx_data[64*k +: 64] = slot_data[k];
        end
    end
    assign child_tx_valid = slot_valid;

    // Upstream merge: one-entry register fed by the round-robin winner.
    logic [NUM_CHILDREN-1:0] grant;
    logic [IDX_W-1:0]        grant_idx;
    logic [63:0]             rx_word;
    logic                    up_free, transfer;

    assign up_free        = !ctrl_out_valid || ctrl_out_ready;
    assign child_rx_ready = (reset && up_free) ? grant : '0;
    assign transfer       = |child_rx_ready;

    rr_arbiter #(.N(NUM_CHILDREN)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (child_rx_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        rx_word = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            if (grant[k]) begin
                rx_word = child_rx_data[64*k +: 64];
                rx_word[ID_MSB -: ID_W] = ID_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_out_valid <= 1'b0;
            ctrl_out_data  <= '0;
        end else if (transfer) begin
            ctrl_out_valid <= 1'b1;
            ctrl_out_data  <= rx_word;
        end else if (ctrl_out_ready) begin
            ctrl_out_valid <= 1'b0;
        end
    end

    assign hub_busy = (|slot_valid) || (state == ST_BCAST) || ctrl_out_valid;

endmodule

// File: tb/tb_parent_link_hub.sv
// Directed bench for parent_link_hub with four children: unicast, drops,
// broadcast behind a blocked child, upstream round-robin, stalls, reset.
module tb_parent_link_hub;
    import hub_pkg::*;

    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [63:0]     ctrl_in_data;
    logic            ctrl_in_valid;
    logic            ctrl_in_ready;
    logic [63:0]     ctrl_out_data;
    logic            ctrl_out_valid;
    logic            ctrl_out_ready;
    logic [64*NC-1:0] child_tx_data;
    logic [NC-1:0]   child_tx_valid;
    logic [NC-1:0]   child_tx_ready;
    logic [64*NC-1:0] child_rx_data;
    logic [NC-1:0]   child_rx_valid;
    logic [NC-1:0]   child_rx_ready;
    logic [15:0]     drop_count;
    logic            hub_busy;
    hub_state_t      fsm_state;

    int errors = 0;
    int checks = 0;

    parent_link_hub #(.NUM_CHILDREN(NC), .ID_MSB(63)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_in_data   (ctrl_in_data),
        .ctrl_in_valid  (ctrl_in_valid),
        .ctrl_in_ready  (ctrl_in_ready),
        .ctrl_out_data  (ctrl_out_data),
        .ctrl_out_valid (ctrl_out_valid),
        .ctrl_out_ready (ctrl_out_ready),
        .child_tx_data  (child_tx_data),
        .child_tx_valid (child_tx_valid),
        .child_tx_ready (child_tx_ready),
        .child_rx_data  (child_rx_data),
        .child_rx_valid (child_rx_valid),
        .child_rx_ready (child_rx_ready),
        .drop_count     (drop_count),
        .hub_busy       (hub_busy),
        .fsm_state      (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tx_slice(input int k);
        return child_tx_data[64*k +: 64];
    endfunction

    function automatic logic [63:0] up_word(input int k);
        logic [63:0] w;
        w = {4'h0, 52'h0, 8'(k)};
        w[63:60] = 4'(k + 1);
        return w;
    endfunction

    localparam logic [63:0] W_UNI  = 64'h2000_0000_0000_00AB;
    localparam logic [63:0] W_C3   = 64'h3000_0000_0000_0055;
    localparam logic [63:0] W_BC   = 64'hF000_0000_0000_0001;
    localparam logic [63:0] W_C1   = 64'h1000_0000_0000_0077;

    initial begin
        reset          = 1'b0;
        ctrl_in_data   = 64'h0000_0000_0000_0011;
        ctrl_in_valid  = 1'b1;
        ctrl_out_ready = 1'b1;
        child_tx_ready = 4'b1111;
        child_rx_valid = 4'b1111;
        for (int k = 0; k < NC; k++) child_rx_data[64*k +: 64] = {4'hA, 52'h0, 8'(k)};

        // reset state
        tick(); tick();
        chk("rst_in_ready", 64'(ctrl_in_ready), 64'd0);
        chk("rst_rx_ready", 64'(child_rx_ready), 64'd0);
        chk("rst_out_valid", 64'(ctrl_out_valid), 64'd0);
        chk("rst_tx_valid", 64'(child_tx_valid), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_busy", 64'(hub_busy), 64'd0);
        chk("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        ctrl_in_valid  = 1'b0;
        child_rx_valid = 4'b0000;
        tick();
        reset = 1'b1;
        tick();

        // unicast to ID 2 -> slot 1
        ctrl_in_data = W_UNI; ctrl_in_valid = 1'b1; #1;
        chk("uni_ready", 64'(ctrl_in_ready), 64'd1);
        tick();
        ctrl_in_valid = 1'b0; #1;
        chk("uni_valid", 64'(child_tx_valid), 64'b0010);
        chk("uni_data", tx_slice(1), W_UNI);
        tick();
        chk("uni_drain", 64'(child_tx_valid), 64'd0);

        // back-to-back unicasts to ID 3
        for (int i = 0; i < 3; i++) begin
            ctrl_in_data = {4'h3, 52'h0, 8'(8'h40 + i)}; ctrl_in_valid = 1'b1; #1;
            chk("b2b_ready", 64'(ctrl_in_ready), 64'd1);
            tick();
            ctrl_in_valid = 1'b0; #1;
            chk("b2b_valid", 64'(child_tx_valid), 64'b0100);
            chk("b2b_data", tx_slice(2), {4'h3, 52'h0, 8'(8'h40 + i)});
        end
        tick();
        chk("b2b_drain", 64'(child_tx_valid), 64'd0);

        // illegal IDs 0 and 9
        ctrl_in_data = 64'h0000_0000_0000_0011; ctrl_in_valid = 1'b1; #1;
        chk("drop0_ready", 64'(ctrl_in_ready), 64'd1);
        tick();
        ctrl_in_data = 64'h9000_0000_0000_0022; #1;
        chk("drop9_ready", 64'(ctrl_in_ready), 64'd1);
        tick();
        ctrl_in_valid = 1'b0; #1;
        chk("drop_no_tx", 64'(child_tx_valid), 64'd0);
        chk("drop_count2", 64'(drop_count), 64'd2);

        // saturation: 65535 more drops -> 65537 total
        ctrl_in_data = 64'h0000_0000_0000_0033; ctrl_in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        ctrl_in_valid = 1'b0; #1;
        chk("drop_sat", 64'(drop_count), 64'hFFFF);
        chk("drop_sat_tx", 64'(child_tx_valid), 64'd0);

        // broadcast with child 2 blocked and its slot already occupied
        child_tx_ready = 4'b1011;
        ctrl_in_data = W_C3; ctrl_in_valid = 1'b1; #1;
        chk("bc_pre_ready", 64'(ctrl_in_ready), 64'd1);
        tick();
        ctrl_in_data = W_BC; #1;
        chk("bc_pre_valid", 64'(child_tx_valid), 64'b0100);
        chk("bc_accept_ready", 64'(ctrl_in_ready), 64'd1);
        tick();
        ctrl_in_data = W_C1; #1;
        chk("bc_state", 64'(fsm_state), 64'(ST_BCAST));
        chk("bc_hold_ready", 64'(ctrl_in_ready), 64'd0);
        chk("bc_n1_valid", 64'(child_tx_valid), 64'b0100);
        chk("bc_busy", 64'(hub_busy), 64'd1);
        tick();
        chk("bc_n2_valid", 64'(child_tx_valid), 64'b1111);
        chk("bc_n2_c0", tx_slice(0), W_BC);
        chk("bc_n2_c1", tx_slice(1), W_BC);
        chk("bc_n2_c3", tx_slice(3), W_BC);
        chk("bc_n2_c2_old", tx_slice(2), W_C3);
        chk("bc_n2_ready", 64'(ctrl_in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bc_wait_valid", 64'(child_tx_valid), 64'b0100);
            chk("bc_wait_ready", 64'(ctrl_in_ready), 64'd0);
        end
        child_tx_ready = 4'b1111; #1;
        chk("bc_release_ready", 64'(ctrl_in_ready), 64'd0);
        tick();
        chk("bc_c2_valid", 64'(child_tx_valid), 64'b0100);
        chk("bc_c2_data", tx_slice(2), W_BC);
        chk("bc_idle", 64'(fsm_state), 64'(ST_IDLE));
        chk("bc_ready_back", 64'(ctrl_in_ready), 64'd1);
        tick();
        ctrl_in_valid = 1'b0; #1;
        chk("bc_next_valid", 64'(child_tx_valid), 64'b0001);
        chk("bc_next_data", tx_slice(0), W_C1);
        tick();
        chk("bc_all_drain", 64'(child_tx_valid), 64'd0);

        // upstream round robin, all children requesting
        child_rx_valid = 4'b1111; #1;
        chk("rr_first_grant", 64'(child_rx_ready), 64'b0001);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("rr_out_valid", 64'(ctrl_out_valid), 64'd1);
            chk("rr_out_data", ctrl_out_data, up_word((j - 1) % 4));
        end

        // upstream stall: child 3 word must be held, nothing granted
        ctrl_out_ready = 1'b0; #1;
        chk("stall_rx_ready", 64'(child_rx_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_hold", ctrl_out_data, up_word(3));
            chk("stall_grant", 64'(child_rx_ready), 64'd0);
        end
        ctrl_out_ready = 1'b1; #1;
        chk("release_grant", 64'(child_rx_ready), 64'b0001);
        tick();
        chk("release_w0", ctrl_out_data, up_word(0));
        tick();
        child_rx_valid = 4'b0000;
        chk("release_w1", ctrl_out_data, up_word(1));
        tick();
        chk("up_idle", 64'(ctrl_out_valid), 64'd0);

        // reset mid-broadcast
        child_tx_ready = 4'b1011;
        ctrl_in_data = W_C3; ctrl_in_valid = 1'b1;
        tick();
        ctrl_in_data = W_BC;
        tick();
        ctrl_in_valid = 1'b0; #1;
        chk("mid_state", 64'(fsm_state), 64'(ST_BCAST));
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; #1;
        chk("mid_tx_valid", 64'(child_tx_valid), 64'd0);
        chk("mid_state_idle", 64'(fsm_state), 64'(ST_IDLE));
        chk("mid_drop", 64'(drop_count), 64'd0);
        chk("mid_busy", 64'(hub_busy), 64'd0);
        child_tx_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_deliver", 64'(child_tx_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parent_link_hub.md
# parent_link_hub

Root-side endpoint of the 64-bit parent link used by every single-FPGA decoder core. It drives each child's parent receive channel and collects each child's parent transmit channel. Downstream control words from the root controller are routed by destination FPGA ID (unicast or broadcast). Upstream words from the children are merged through a round-robin arbiter into one stream, with the source ID stamped on each word.

## Interface
Parameters:
- NUM_CHILDREN, 4, number of child FPGAs (IDs 1..NUM_CHILDREN); legal range 1..14
- ID_MSB, 63, top bit of the 4-bit ID field [ID_MSB:ID_MSB-3]

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (sampled on rising clk)
- ctrl_in_data  in  64  downstream word from root controller; [63:60] = destination ID
- ctrl_in_valid  in  1  downstream word valid
- ctrl_in_ready  out  1  downstream word accepted when valid&ready
- ctrl_out_data  out  64  upstream word to root controller; [63:60] = source ID
- ctrl_out_valid  out  1  upstream valid
- ctrl_out_ready  in  1  upstream ready
- child_tx_data  out  64*NUM_CHILDREN  to child k's parent receive port; slice k = [64k+63:64k]
- child_tx_valid  out  NUM_CHILDREN  per-child valid
- child_tx_ready  in  NUM_CHILDREN  per-child ready
- child_rx_data  in  64*NUM_CHILDREN  from child k's parent transmit port
- child_rx_valid  in  NUM_CHILDREN  per-child valid
- child_rx_ready  out  NUM_CHILDREN  per-child ready
- drop_count  out  16  saturating count of discarded downstream words
- hub_busy  out  1  any slot full, broadcast pending, or upstream register full

## Operation
- Handshake rules: all channels use valid/ready. A valid, once raised, holds its data stable until ready.
- Downstream slots: each child has a 1-entry output slot. A slot is free when empty or when it drains in the same cycle (valid&ready).
- Destination decode from [63:60]:
  - d in 1..NUM_CHILDREN: unicast to slot d-1.
  - 4'hF: broadcast.
  - Any other value: drop.
- FSM states IDLE and BCAST.
  - IDLE, unicast: ctrl_in_ready = target slot free. On accept, the word is loaded into that slot.
  - IDLE, drop: ctrl_in_ready = 1. On accept, drop_count increments, saturating at 16'hFFFF.
  - IDLE, broadcast: ctrl_in_ready = 1. On accept, the word is latched into the bcast register, done_mask is cleared, and the FSM moves to BCAST.
  - BCAST: ctrl_in_ready = 0. Every cycle, each free slot whose done_mask bit is 0 is loaded and its bit is set. When done_mask is all ones after the update, the FSM returns to IDLE.
- The data word is forwarded unmodified downstream, including the ID field.
- Upstream path:
  - Round-robin arbiter over child_rx_valid.
  - Grant requires the 1-entry upstream register to be free (empty or draining).
  - child_rx_ready is one-hot on the granted child, otherwise 0.
  - The accepted word is stored with [63:60] overwritten by k+1.
  - The round-robin pointer moves to k+1 (mod NUM_CHILDREN) only after a transfer.

## Timing
- Reset values: ctrl_in_ready=0, ctrl_out_valid=0, child_tx_valid=0, child_rx_ready=0, drop_count=0, hub_busy=0, FSM=IDLE, RR pointer=0, done_mask=0. Data registers are cleared to 0.
- ctrl_in_ready and child_rx_ready are combinational from state and downstream ready; they are forced to 0 while reset is low.
- Downstream latency: word accepted at cycle n appears on child_tx at n+1. A broadcast reaches every free slot at n+2 (one cycle for BCAST entry). Back-to-back unicasts to one child sustain 1 word/cycle.
- Upstream latency: word accepted at cycle n appears on ctrl_out at n+1. Throughput is 1 word/cycle total.
- Simultaneous events:
  - A slot draining and reloading in the same cycle is legal.
  - A new request from the child just granted waits one full round if others are requesting.
- Reset asserted mid-broadcast discards the pending broadcast and all slot contents, with no partial delivery afterward.
- Stalls: a blocked child (ready stuck low) stalls unicasts to itself, and broadcasts, only. Other children's unicasts stall behind it only while it is the current ctrl_in head.

## Structure
- Shared package hub_pkg: ID_BROADCAST=4'hF, ID field width 4, and a link_word typedef (struct: id[3:0], payload[59:0]).
- Sub-module rr_arbiter, parameterised by requester count. Outputs one-hot grant and grant index, plus an advance input. It is reusable by the message handler.

## Test plan
- Unicast: ctrl_in word 64'h2000_0000_0000_00AB with all child ready=1 -> child 1 valid at +1 with identical data; other children idle.
- Broadcast with child 2 ready=0 for 5 cycles: word 64'hF000…01 -> children 0,1,3 receive it at +2. Child 2 receives it when ready rises. ctrl_in_ready stays 0 until then, then rises the cycle after.
- Illegal ID 4'h0 and 4'h9 (NUM_CHILDREN=4) -> ctrl_in_ready=1, no child valid, drop_count=2. Force 65537 drops -> drop_count=16'hFFFF.
- All 4 children hold valid continuously, payload = index -> ctrl_out order 1,2,3,4,1,… with [63:60] stamped 1..4 regardless of the child's original ID bits.
- ctrl_out_ready=0 for 10 cycles -> exactly one word held, all child_rx_ready=0, no loss or duplication after release.
- Assert reset low for one cycle mid-BCAST -> all valids 0 next cycle, FSM IDLE, undelivered children never receive the word.
